scsi_port_cycle: RTL

SCSI_PORT_CYCLE -- requirements
Module: scsi_port_cycle

---
 rtl/scsi_port_cycle.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/scsi_port_cycle.sv
// -----------------------------------------------------------------------------
// scsi_port_cycle
//
// Purpose:
//   Generates one programmed-I/O bus cycle to a WD33C93A SCSI controller.
//   A request from the CPU-side address decode starts a fixed sequence:
//   chip select setup, read or write strobe, chip select hold, then a
//   one-cycle completion pulse. The phase lengths are set by parameters.
//   The cycle can be cut short by the CPU negating its address strobe.
//   Every output is registered, so the peripheral pins are glitch-free.
//
// Parameters:
//   T_SETUP  - cycles of _CSS low before the strobe (min 1, max 16)
//   T_STROBE - cycles of _IOR/_IOW low              (min 1, max 16)
//   T_HOLD   - cycles of _CSS low after the strobe  (min 1, max 16)
//
// Ports:
//   SCLK   in   clock; every state change happens on its rising edge
//   RST    in   synchronous active-high reset
//   REQ    in   start request, looked at only while idle
//   RW     in   direction of the requested cycle (1 = read, 0 = write)
//   ABORT  in   CPU address strobe negated early (level)
//   DIN    in   [7:0] byte to write
//   DOUT   out  [7:0] last byte read from the peripheral
//   ACK    out  one-cycle completion pulse toward the DSACK logic
//   BUSY   out  high whenever a cycle is in progress
//   PD_IN  in   [7:0] peripheral data bus, input side
//   PD_OUT out  [7:0] peripheral data bus, output side
//   PD_OE  out  output enable for PD_OUT (active high)
//   _CSS   out  chip select (active low)
//   _IOR   out  read strobe (active low)
//   _IOW   out  write strobe (active low)
// -----------------------------------------------------------------------------
module scsi_port_cycle #(
  parameter int T_SETUP  = 1,
  parameter int T_STROBE = 4,
  parameter int T_HOLD   = 1
) (
  input  logic       SCLK,
  input  logic       RST,
  input  logic       REQ,
  input  logic       RW,
  input  logic       ABORT,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       ACK,
  output logic       BUSY,
  input  logic [7:0] PD_IN,
  output logic [7:0] PD_OUT,
  output logic       PD_OE,
  output logic       _CSS,
  output logic       _IOR,
  output logic       _IOW
);

  // Phase lengths are clamped to what a 4-bit down-counter can time
  // without wrapping: the counter is loaded with length-1 and the phase
  // ends when it reaches zero.
  localparam int SETUP_LEN  = (T_SETUP  < 1) ? 1 : ((T_SETUP  > 16) ? 16 : T_SETUP);
  localparam int STROBE_LEN = (T_STROBE < 1) ? 1 : ((T_STROBE > 16) ? 16 : T_STROBE);
  localparam int HOLD_LEN   = (T_HOLD   < 1) ? 1 : ((T_HOLD   > 16) ? 16 : T_HOLD);

  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_LEN  - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_LEN - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_LEN   - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_ACK    = 3'd4
  } state_t;

  state_t     state_reg,   state_next;
  logic [3:0] cnt_reg,     cnt_next;
  logic       dir_reg,     dir_next;      // 1 = read
  logic [7:0] wdata_reg,   wdata_next;
  logic       aborted_reg, aborted_next;  // strobe was cut short: suppress ACK
  logic [7:0] dout_reg,    dout_next;
  logic [7:0] pd_out_reg,  pd_out_next;
  logic       pd_oe_reg,   pd_oe_next;
  logic       css_reg,     css_next;
  logic       ior_reg,     ior_next;
  logic       iow_reg,     iow_next;
  logic       ack_reg,     ack_next;
  logic       busy_reg,    busy_next;

  logic       select_next; // chip is selected in the next cycle

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge SCLK) begin
    if (RST) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= 4'd0;
      dir_reg     <= 1'b0;
      wdata_reg   <= 8'h00;
      aborted_reg <= 1'b0;
      dout_reg    <= 8'h00;
      pd_out_reg  <= 8'h00;
      pd_oe_reg   <= 1'b0;
      css_reg     <= 1'b1;
      ior_reg     <= 1'b1;
      iow_reg     <= 1'b1;
      ack_reg     <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      dir_reg     <= dir_next;
      wdata_reg   <= wdata_next;
      aborted_reg <= aborted_next;
      dout_reg    <= dout_next;
      pd_out_reg  <= pd_out_next;
      pd_oe_reg   <= pd_oe_next;
      css_reg     <= css_next;
      ior_reg     <= ior_next;
      iow_reg     <= iow_next;
      ack_reg     <= ack_next;
      busy_reg    <= busy_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    dir_next     = dir_reg;
    wdata_next   = wdata_reg;
    aborted_next = aborted_reg;
    dout_next    = dout_reg;

    case (state_reg)
      ST_IDLE: begin
        aborted_next = 1'b0;
        cnt_next     = 4'd0;
        if (REQ) begin
          dir_next   = RW;
          wdata_next = DIN;
          state_next = ST_SETUP;
          cnt_next   = SETUP_LOAD;
        end
      end

      ST_SETUP: begin
        if (ABORT) begin
          // Nothing has been strobed yet, so simply drop the select.
          state_next = ST_IDLE;
          cnt_next   = 4'd0;
        end else if (cnt_reg == 4'd0) begin
          state_next = ST_STROBE;
          cnt_next   = STROBE_LOAD;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      ST_STROBE: begin
        if (ABORT) begin
          // Negate the strobe now but still honour the hold time so the
          // peripheral sees a clean select deassertion; the read data is
          // not trusted and ACK is withheld.
          state_next   = ST_HOLD;
          cnt_next     = HOLD_LOAD;
          aborted_next = 1'b1;
        end else if (cnt_reg == 4'd0) begin
          state_next = ST_HOLD;
          cnt_next   = HOLD_LOAD;
          if (dir_reg) begin
            dout_next = PD_IN;
          end
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      ST_HOLD: begin
        if (cnt_reg == 4'd0) begin
          state_next = aborted_reg ? ST_IDLE : ST_ACK;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      ST_ACK: begin
        state_next = ST_IDLE;
        cnt_next   = 4'd0;
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state, so the pins change on the same edge
  // as the state they belong to.
  // ---------------------------------------------------------------------------
  always_comb begin
    select_next = (state_next == ST_SETUP) ||
                  (state_next == ST_STROBE) ||
                  (state_next == ST_HOLD);

    css_next   = ~select_next;
    ior_next   = ~((state_next == ST_STROBE) &&  dir_next);
    iow_next   = ~((state_next == ST_STROBE) && !dir_next);
    pd_oe_next = select_next && !dir_next;
    ack_next   = (state_next == ST_ACK);
    busy_next  = (state_next != ST_IDLE);

    // The data bus keeps its last driven value while released.
    pd_out_next = pd_oe_next ? wdata_next : pd_out_reg;
  end

  assign DOUT   = dout_reg;
  assign ACK    = ack_reg;
  assign BUSY   = busy_reg;
  assign PD_OUT = pd_out_reg;
  assign PD_OE  = pd_oe_reg;
  assign _CSS   = css_reg;
  assign _IOR   = ior_reg;
  assign _IOW   = iow_reg;

endmodule
